// File: rtl/saturn_pc_rstk_sched.sv
// saturn_pc_rstk_sched: 4-phase sequencer and PC/RSTK command arbiter with stack-depth tracking
module saturn_pc_rstk_sched #(
  parameter int RSTK_DEPTH = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_bus_busy,
  output logic [1:0]  o_phase,
  output logic [3:0]  o_phases,
  output logic [31:0] o_cycle_ctr,
  input  logic        i_exec_req,
  input  logic [2:0]  i_exec_op,
  input  logic [19:0] i_exec_data,
  output logic        o_exec_gnt,
  input  logic        i_dbg_req,
  input  logic [2:0]  i_dbg_op,
  input  logic [19:0] i_dbg_data,
  output logic        o_dbg_gnt,
  output logic        o_cmd_valid,
  output logic [2:0]  o_cmd_op,
  output logic [19:0] o_cmd_data,
  output logic [3:0]  o_rstk_depth,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_busy
);
  typedef enum logic {IDLE, ARMED} state_t;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_d;
  logic adv, arb, issue, exec_win, push, pop, legal;
  logic [SW-1:0] starve_cnt;
  logic [2:0] lat_op;
  logic [19:0] lat_data;
  assign adv = i_clk_en && !i_bus_busy;
  assign o_phases = adv ? 4'b0001 << o_phase : 4'b0000;
  assign o_busy = state == ARMED;
  assign push = lat_op == 3'd2 || lat_op == 3'd4;
  assign pop = lat_op == 3'd3 || lat_op == 3'd5;
  assign legal = lat_op == 3'd1 || push || pop;
  // arbitration point, issue point and next-state decode
  always_comb begin
    arb = adv && state == IDLE && o_phase == 2'd2;
    issue = adv && state == ARMED && o_phase == 2'd3;
    exec_win = i_exec_req && (!i_dbg_req || starve_cnt == SW'(STARVE_LIMIT));
    state_d = (arb && (i_exec_req || i_dbg_req)) ? ARMED : issue ? IDLE : state;
  end
  // FSM state register
  always_ff @(posedge i_clk) state <= i_reset ? IDLE : state_d;
  // phase/cycle counters, grant latching, command issue and depth tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_phase <= '0;
      o_cycle_ctr <= '0;
      o_exec_gnt <= 1'b0;
      o_dbg_gnt <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd_op <= '0;
      o_cmd_data <= '0;
      o_rstk_depth <= '0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
      starve_cnt <= '0;
      lat_op <= '0;
      lat_data <= '0;
    end else begin
      o_exec_gnt <= arb && exec_win;
      o_dbg_gnt <= arb && i_dbg_req && !exec_win;
      o_cmd_valid <= issue && legal;
      o_overflow <= issue && push && o_rstk_depth == 4'(RSTK_DEPTH);
      o_underflow <= issue && pop && o_rstk_depth == 4'd0;
      if (adv) o_phase <= o_phase + 2'd1;
      if (adv && o_phase == 2'd3) o_cycle_ctr <= o_cycle_ctr + 32'd1;
      if (arb && (i_exec_req || i_dbg_req)) begin
        lat_op <= exec_win ? i_exec_op : i_dbg_op;
        lat_data <= exec_win ? i_exec_data : i_dbg_data;
      end
      if (arb) starve_cnt <= (!i_exec_req || exec_win) ? '0 : (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
      if (issue && legal) begin
        o_cmd_op <= lat_op;
        o_cmd_data <= lat_data;
      end
      if (issue && push && o_rstk_depth != 4'(RSTK_DEPTH)) o_rstk_depth <= o_rstk_depth + 4'd1;
      if (issue && pop && o_rstk_depth != 4'd0) o_rstk_depth <= o_rstk_depth - 4'd1;
    end
  end
endmodule

// File: tb/tb_saturn_pc_rstk_sched.sv
// tb_saturn_pc_rstk_sched: directed and random checks against a behavioural instruction-cycle model
module tb_saturn_pc_rstk_sched;
  localparam int RD = 8;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, clk_en = 1'b0, bus_busy = 1'b0, exec_req = 1'b0, dbg_req = 1'b0;
  logic [2:0] exec_op = '0, dbg_op = '0;
  logic [19:0] exec_data = '0, dbg_data = '0;
  logic [1:0] o_phase;
  logic [3:0] o_phases, o_rstk_depth;
  logic [31:0] o_cycle_ctr;
  logic o_exec_gnt, o_dbg_gnt, o_cmd_valid, o_overflow, o_underflow, o_busy;
  logic [2:0] o_cmd_op;
  logic [19:0] o_cmd_data;
  int total = 0, bad = 0;
  int n_ov = 0, n_un = 0, n_eg = 0, n_dg = 0;
  int m_phase, m_depth, m_starve;
  logic [31:0] m_ctr;
  bit m_armed, m_egnt, m_dgnt, m_cv, m_ov, m_un;
  logic [2:0] m_op, m_cop;
  logic [19:0] m_data, m_cdata;

  always #5 clk = ~clk;

  saturn_pc_rstk_sched #(.RSTK_DEPTH(RD), .STARVE_LIMIT(SL)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_bus_busy(bus_busy),
    .o_phase(o_phase), .o_phases(o_phases), .o_cycle_ctr(o_cycle_ctr),
    .i_exec_req(exec_req), .i_exec_op(exec_op), .i_exec_data(exec_data), .o_exec_gnt(o_exec_gnt),
    .i_dbg_req(dbg_req), .i_dbg_op(dbg_op), .i_dbg_data(dbg_data), .o_dbg_gnt(o_dbg_gnt),
    .o_cmd_valid(o_cmd_valid), .o_cmd_op(o_cmd_op), .o_cmd_data(o_cmd_data),
    .o_rstk_depth(o_rstk_depth), .o_overflow(o_overflow), .o_underflow(o_underflow), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock edge of the instruction-cycle model, using the inputs applied at that edge
  function automatic void model_edge();
    bit ex;
    m_egnt = 0; m_dgnt = 0; m_cv = 0; m_ov = 0; m_un = 0;
    if (rst) begin
      m_phase = 0; m_ctr = 0; m_armed = 0; m_starve = 0; m_cop = 0; m_cdata = 0; m_depth = 0;
      return;
    end
    if (!clk_en || bus_busy) return;
    if (!m_armed && m_phase == 2) begin
      ex = exec_req && (!dbg_req || m_starve == SL);
      if (exec_req || dbg_req) begin
        m_armed = 1;
        m_op = ex ? exec_op : dbg_op;
        m_data = ex ? exec_data : dbg_data;
        m_egnt = ex;
        m_dgnt = !ex;
      end
      m_starve = (!exec_req || ex) ? 0 : (m_starve < SL ? m_starve + 1 : SL);
    end else if (m_armed && m_phase == 3) begin
      m_armed = 0;
      if (m_op inside {[1:5]}) begin m_cv = 1; m_cop = m_op; m_cdata = m_data; end
      if (m_op inside {3'd2, 3'd4}) begin if (m_depth == RD) m_ov = 1; else m_depth++; end
      if (m_op inside {3'd3, 3'd5}) begin if (m_depth == 0) m_un = 1; else m_depth--; end
    end
    if (m_phase == 3) m_ctr++;
    m_phase = (m_phase + 1) % 4;
  endfunction

  task automatic step();
    #1;
    chk("phases", o_phases, (clk_en && !bus_busy) ? 32'd1 << m_phase : 32'd0);
    chk("busy", o_busy, m_armed);
    @(posedge clk);
    model_edge();
    #1;
    chk("phase", o_phase, m_phase);
    chk("cycle_ctr", o_cycle_ctr, m_ctr);
    chk("exec_gnt", o_exec_gnt, m_egnt);
    chk("dbg_gnt", o_dbg_gnt, m_dgnt);
    chk("cmd_valid", o_cmd_valid, m_cv);
    chk("cmd_op", o_cmd_op, m_cop);
    chk("cmd_data", o_cmd_data, m_cdata);
    chk("depth", o_rstk_depth, m_depth);
    chk("overflow", o_overflow, m_ov);
    chk("underflow", o_underflow, m_un);
    n_ov += int'(o_overflow); n_un += int'(o_underflow);
    n_eg += int'(o_exec_gnt); n_dg += int'(o_dbg_gnt);
    if (m_egnt) exec_req = 0;
    if (m_dgnt) dbg_req = 0;
  endtask

  task automatic serve(input bit ex, input logic [2:0] op, input logic [19:0] d);
    int n = 0;
    if (ex) begin exec_req = 1; exec_op = op; exec_data = d; end
    else begin dbg_req = 1; dbg_op = op; dbg_data = d; end
    do begin step(); n++; end while ((exec_req || dbg_req || m_armed) && n < 40);
    chk("serve_timeout", n < 40, 1);
  endtask

  task automatic drain();
    int n = 0;
    exec_req = 0; dbg_req = 0;
    while (m_armed && n < 20) begin step(); n++; end
    chk("drain_timeout", n < 20, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    m_phase = 0; m_ctr = 0; m_armed = 0; m_starve = 0; m_cop = 0; m_cdata = 0; m_depth = 0;
    m_op = 0; m_data = 0;
    chk("rst_phase", o_phase, 0);
    chk("rst_ctr", o_cycle_ctr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_depth", o_rstk_depth, 0);
    chk("rst_cmd", {o_cmd_valid, o_cmd_op, o_cmd_data}, 0);
    rst = 0; clk_en = 1;
    repeat (8) step();
    chk("ctr_after_8", o_cycle_ctr, 2);
    chk("gnts_none", n_eg + n_dg, 0);
    serve(1, 3'd2, 20'h12345);
    chk("call_depth", o_rstk_depth, 1);
    chk("call_op", o_cmd_op, 2);
    n_eg = 0; n_dg = 0;
    for (int i = 0; i < 24; i++) begin
      dbg_req = 1; dbg_op = 3'd4; dbg_data = 20'h0abcd;
      exec_req = 1; exec_op = 3'd1; exec_data = 20'h00777;
      step();
    end
    chk("starve_dbg", n_dg, 5);
    chk("starve_exec", n_eg, 1);
    drain();
    rst = 1; step(); rst = 0;
    n_ov = 0; n_un = 0;
    for (int i = 0; i < 9; i++) serve(1, 3'd4, 20'(i));
    chk("push_full", o_rstk_depth, 8);
    chk("ov_count", n_ov, 1);
    for (int i = 0; i < 9; i++) serve(1, 3'd5, 20'(i));
    chk("pop_empty", o_rstk_depth, 0);
    chk("un_count", n_un, 1);
    exec_req = 1; exec_op = 3'd1; exec_data = 20'hfedcb;
    n = 0;
    while (!(m_armed && m_phase == 3) && n < 20) begin step(); n++; end
    chk("arm_timeout", n < 20, 1);
    bus_busy = 1;
    repeat (5) step();
    chk("busy_frozen", o_busy, 1);
    bus_busy = 0;
    step();
    chk("issue_after_busy", o_cmd_valid, 1);
    chk("issue_data", o_cmd_data, 20'hfedcb);
    exec_req = 1; exec_op = 3'd2; exec_data = 20'h0beef;
    n = 0;
    while (!m_armed && n < 20) begin step(); n++; end
    rst = 1; step(); rst = 0;
    chk("rst_armed_busy", o_busy, 0);
    chk("rst_armed_valid", o_cmd_valid, 0);
    serve(1, 3'd2, 20'h0beef);
    chk("rereq_depth", o_rstk_depth, 1);
    for (int i = 0; i < 400; i++) begin
      clk_en = $urandom_range(0, 9) != 0;
      bus_busy = $urandom_range(0, 4) == 0;
      rst = $urandom_range(0, 99) == 0;
      if (!exec_req && $urandom_range(0, 3) == 0) begin
        exec_req = 1; exec_op = 3'($urandom_range(0, 7)); exec_data = 20'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_op = 3'($urandom_range(0, 7)); dbg_data = 20'($urandom);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
